// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: serialises the two load/store slots of a VLIW bundle
// (slot0 first, then slot1) over one fixed-latency data-memory port and
// holds the pipeline with stall until every requested access has finished.
// Optional feature macro: STORE_FWD_EN (slot0 store -> slot1 load to the same
// address is forwarded and the slot1 memory access is skipped).
module dmem_port_arbiter #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              resp_valid,
    output logic              stall,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISS,
        S_WAIT,
        S_RESP
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic               sel;
    logic [CNT_W-1:0]   cnt;
    logic               cap_req1;
    logic               cap_we0;
    logic               cap_we1;
    logic [ADDR_W-1:0]  cap_addr0;
    logic [ADDR_W-1:0]  cap_addr1;
    logic [DATA_W-1:0]  cap_wdata0;
    logic [DATA_W-1:0]  cap_wdata1;
    logic               fwd_hit;
    logic               sel_we;

`ifdef STORE_FWD_EN
    assign fwd_hit = cap_we0 && cap_req1 && !cap_we1 && (cap_addr0 == cap_addr1);
`else
    assign fwd_hit = 1'b0;
`endif

    assign sel_we = sel ? cap_we1 : cap_we0;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (req0 || req1) state_nxt = S_ISS;
            S_ISS:  state_nxt = S_WAIT;
            S_WAIT: begin
                if (cnt == '0) begin
                    if (!sel && cap_req1 && !fwd_hit) state_nxt = S_ISS;
                    else                             state_nxt = S_RESP;
                end
            end
            S_RESP: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Capture registers, slot select, latency counter and load results
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel        <= 1'b0;
            cnt        <= '0;
            cap_req1   <= 1'b0;
            cap_we0    <= 1'b0;
            cap_we1    <= 1'b0;
            cap_addr0  <= '0;
            cap_addr1  <= '0;
            cap_wdata0 <= '0;
            cap_wdata1 <= '0;
            rdata0     <= '0;
            rdata1     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req0 || req1) begin
                        cap_req1   <= req1;
                        cap_we0    <= we0;
                        cap_we1    <= we1;
                        cap_addr0  <= addr0;
                        cap_addr1  <= addr1;
                        cap_wdata0 <= wdata0;
                        cap_wdata1 <= wdata1;
                        sel        <= !req0;
                    end
                end
                S_ISS: cnt <= CNT_W'(MEM_LAT - 1);
                S_WAIT: begin
                    if (cnt == '0) begin
                        if (!sel_we) begin
                            if (sel) rdata1 <= mem_rdata;
                            else     rdata0 <= mem_rdata;
                        end
                        // Forwarding finishes the bundle here, so slot1 is never selected.
                        if (!sel && cap_req1) begin
                            if (fwd_hit) rdata1 <= cap_wdata0;
                            else         sel    <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Memory strobe, selected-slot fields, handshake outputs
    always_comb begin
        mem_en     = (state == S_ISS);
        mem_we     = sel_we;
        mem_addr   = sel ? cap_addr1 : cap_addr0;
        mem_wdata  = sel ? cap_wdata1 : cap_wdata0;
        resp_valid = (state == S_RESP);
        // Reset forces stall low even while a request is still presented.
        stall      = !reset && (state != S_RESP) &&
                     ((state != S_IDLE) || req0 || req1);
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed testbench for dmem_port_arbiter with a MEM_LAT-deep memory model.
module tb_dmem_port_arbiter;

    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 16;
    localparam int MEM_LAT = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              req0, req1, we0, we1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic [DATA_W-1:0] rdata0, rdata1;
    logic              resp_valid, stall, mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    dmem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .rdata0(rdata0), .rdata1(rdata1), .resp_valid(resp_valid), .stall(stall),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Memory model: write at the mem_en edge, read data appears MEM_LAT cycles later
    logic [DATA_W-1:0] mem [256];
    logic [DATA_W-1:0] rd_pipe [MEM_LAT];
    logic              poke_en = 1'b0;
    logic [ADDR_W-1:0] poke_addr = '0;
    logic [DATA_W-1:0] poke_data = '0;

    always @(posedge clk) begin
        if (poke_en) mem[poke_addr] <= poke_data;
        if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
        rd_pipe[0] <= mem_en ? mem[mem_addr] : 16'hDEAD;
        for (int i = 1; i < MEM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata = rd_pipe[MEM_LAT-1];

    int checks = 0;
    int failures = 0;
    int n_stall, n_en, resp_cyc;
    int en_cyc [2];
    logic en_we [2];
    logic [ADDR_W-1:0] en_addr [2];
    logic [DATA_W-1:0] en_wdata [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        poke_en = 1'b1; poke_addr = a; poke_data = d;
        tick();
        poke_en = 1'b0;
    endtask

    // Present one bundle, record stall/mem_en activity until resp_valid (bounded)
    task automatic do_bundle(input logic r0, input logic w0, input logic [ADDR_W-1:0] a0,
                             input logic [DATA_W-1:0] d0, input logic r1, input logic w1,
                             input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1);
        req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
        req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
        #1;
        n_stall = 0; n_en = 0; resp_cyc = -1;
        for (int k = 0; k < 2; k++) begin
            en_cyc[k] = -1; en_we[k] = 1'b0; en_addr[k] = '0; en_wdata[k] = '0;
        end
        for (int c = 0; c < 40; c++) begin
            if (stall) n_stall++;
            if (mem_en) begin
                if (n_en < 2) begin
                    en_cyc[n_en] = c; en_we[n_en] = mem_we;
                    en_addr[n_en] = mem_addr; en_wdata[n_en] = mem_wdata;
                end
                n_en++;
            end
            if (resp_valid) begin
                resp_cyc = c;
                break;
            end
            tick();
        end
        req0 = 1'b0; req1 = 1'b0;
        tick();
        chk("post_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("post_stall", {31'b0, stall}, 32'd0);
    endtask

    initial begin
        int bad;
        reset = 1'b1;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", {31'b0, stall}, 32'd0);
        chk("rst_mem_en", {31'b0, mem_en}, 32'd0);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_rdata0", {16'b0, rdata0}, 32'd0);
        chk("rst_rdata1", {16'b0, rdata1}, 32'd0);
        chk("rst_mem_addr", {24'b0, mem_addr}, 32'd0);
        reset = 1'b0;

        poke(8'h10, 16'h1234);
        poke(8'h30, 16'h5555);
        poke(8'h08, 16'h00AA);
        poke(8'h40, 16'h1111);
        poke(8'h50, 16'h7777);
        tick();

        // 1: slot0 load
        do_bundle(1, 0, 8'h10, 16'h0, 0, 0, 8'h00, 16'h0);
        chk("t1_stall", n_stall, 4);
        chk("t1_n_en", n_en, 1);
        chk("t1_en_cyc", en_cyc[0], 1);
        chk("t1_en_addr", {24'b0, en_addr[0]}, 32'h10);
        chk("t1_en_we", {31'b0, en_we[0]}, 0);
        chk("t1_resp_cyc", resp_cyc, 4);
        chk("t1_rdata0", {16'b0, rdata0}, 32'h1234);
        chk("t1_rdata1", {16'b0, rdata1}, 32'h0);

        // 2: slot0 store, slot1 load
        do_bundle(1, 1, 8'h20, 16'hBEEF, 1, 0, 8'h30, 16'h0);
        chk("t2_stall", n_stall, 7);
        chk("t2_n_en", n_en, 2);
        chk("t2_en0_cyc", en_cyc[0], 1);
        chk("t2_en0_we", {31'b0, en_we[0]}, 1);
        chk("t2_en0_addr", {24'b0, en_addr[0]}, 32'h20);
        chk("t2_en0_wdata", {16'b0, en_wdata[0]}, 32'hBEEF);
        chk("t2_en1_cyc", en_cyc[1], 4);
        chk("t2_en1_we", {31'b0, en_we[1]}, 0);
        chk("t2_en1_addr", {24'b0, en_addr[1]}, 32'h30);
        chk("t2_resp_cyc", resp_cyc, 7);
        chk("t2_rdata1", {16'b0, rdata1}, 32'h5555);
        chk("t2_rdata0", {16'b0, rdata0}, 32'h1234);
        chk("t2_mem20", {16'b0, mem[8'h20]}, 32'hBEEF);

        // 3: slot1-only load
        do_bundle(0, 0, 8'h00, 16'h0, 1, 0, 8'h08, 16'h0);
        chk("t3_stall", n_stall, 4);
        chk("t3_n_en", n_en, 1);
        chk("t3_en_addr", {24'b0, en_addr[0]}, 32'h08);
        chk("t3_rdata1", {16'b0, rdata1}, 32'h00AA);
        chk("t3_rdata0", {16'b0, rdata0}, 32'h1234);

        // 4: store then load to the same address
        do_bundle(1, 1, 8'h40, 16'hCAFE, 1, 0, 8'h40, 16'h0);
`ifdef STORE_FWD_EN
        chk("t4_stall", n_stall, 4);
        chk("t4_n_en", n_en, 1);
        chk("t4_resp_cyc", resp_cyc, 4);
`else
        chk("t4_stall", n_stall, 7);
        chk("t4_n_en", n_en, 2);
        chk("t4_resp_cyc", resp_cyc, 7);
        chk("t4_en1_addr", {24'b0, en_addr[1]}, 32'h40);
`endif
        chk("t4_en0_we", {31'b0, en_we[0]}, 1);
        chk("t4_rdata1", {16'b0, rdata1}, 32'hCAFE);
        chk("t4_rdata0", {16'b0, rdata0}, 32'h1234);
        chk("t4_mem40", {16'b0, mem[8'h40]}, 32'hCAFE);

        // 7: both slots store to one address, slot1 data persists
        do_bundle(1, 1, 8'h60, 16'hA5A5, 1, 1, 8'h60, 16'h5A5A);
        chk("t7_stall", n_stall, 7);
        chk("t7_n_en", n_en, 2);
        chk("t7_mem60", {16'b0, mem[8'h60]}, 32'h5A5A);
        chk("t7_rdata0", {16'b0, rdata0}, 32'h1234);
        chk("t7_rdata1", {16'b0, rdata1}, 32'hCAFE);

        // 5: reset in WAIT of a slot0 load, request held across reset
        req0 = 1; we0 = 0; addr0 = 8'h50; req1 = 0;
        tick();
        tick();
        chk("t5_pre_stall", {31'b0, stall}, 1);
        reset = 1'b1;
        #1;
        chk("t5_rst_stall", {31'b0, stall}, 0);
        chk("t5_rst_mem_en", {31'b0, mem_en}, 0);
        chk("t5_rst_resp", {31'b0, resp_valid}, 0);
        chk("t5_rst_rdata0", {16'b0, rdata0}, 32'h0);
        chk("t5_rst_rdata1", {16'b0, rdata1}, 32'h0);
        tick();
        chk("t5_rst_mem_en2", {31'b0, mem_en}, 0);
        chk("t5_rst_stall2", {31'b0, stall}, 0);
        reset = 1'b0;
        do_bundle(1, 0, 8'h50, 16'h0, 0, 0, 8'h00, 16'h0);
        chk("t5_stall", n_stall, 4);
        chk("t5_resp_cyc", resp_cyc, 4);
        chk("t5_rdata0", {16'b0, rdata0}, 32'h7777);

        // 6: no requests for 20 cycles
        bad = 0;
        req0 = 0; req1 = 0;
        for (int c = 0; c < 20; c++) begin
            if (stall !== 1'b0 || mem_en !== 1'b0 || resp_valid !== 1'b0) bad++;
            tick();
        end
        chk("t6_idle_quiet", bad, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
